// File: rtl/round_timer_pkg.sv
// rtl/round_timer_pkg.sv - shared state encoding and time constants for the round timer
package round_timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    PAUSED   = 2'd2,
    EXPIRED  = 2'd3
  } timer_state_t;

  localparam int         SECS_PER_MIN = 60;
  localparam logic [5:0] SECS_MAX     = 6'(SECS_PER_MIN - 1);

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the system clock down to a one-cycle tick every CLK_HZ enabled cycles
module tick_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  // The tick fires on the last enabled count so the consumer sees it in the same cycle it wraps.
  assign tick = enable && (count == LAST);

  // Count only while enabled; holding the value while disabled gives pause/resume without loss.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - round countdown FSM and min:sec counter; ROUND_TIMER_WARN_EN enables the final-seconds warning
module round_timer_ctrl
  import round_timer_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int INIT_MIN  = 2,
  parameter int INIT_SEC  = 0,
  parameter int WARN_SECS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] mins,
  output logic [5:0] secs,
  output logic [1:0] state,
  output logic       running,
  output logic       done,
  output logic       warn
);

  localparam logic [3:0] INIT_M = 4'(INIT_MIN);
  localparam logic [5:0] INIT_S = 6'(INIT_SEC);

  // Reject parameter sets that could load an empty round or an unreachable warning window.
  if (INIT_MIN < 0 || INIT_MIN > 15 || INIT_SEC < 0 || INIT_SEC > 59 ||
      (INIT_MIN == 0 && INIT_SEC == 0) || WARN_SECS < 1 || WARN_SECS > 59) begin : g_bad_params
    $error("round_timer_ctrl: parameter out of range");
  end

  timer_state_t cur_state;
  timer_state_t nxt_state;
  logic [3:0]   nxt_mins;
  logic [5:0]   nxt_secs;
  logic         nxt_done;
  logic         clear_pre;
  logic         count_en;
  logic         tick;

  assign count_en = (cur_state == RUNNING);
  assign state    = cur_state;

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear_pre),
    .enable (count_en),
    .tick   (tick)
  );

  // Next-state and next-time decode; abort outranks start, start outranks pause.
  always_comb begin
    nxt_state = cur_state;
    nxt_mins  = mins;
    nxt_secs  = secs;
    nxt_done  = 1'b0;
    clear_pre = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start) begin
          nxt_state = RUNNING;
          clear_pre = 1'b1;
        end
      end
      RUNNING: begin
        if (abort) begin
          nxt_state = IDLE;
          nxt_mins  = INIT_M;
          nxt_secs  = INIT_S;
          clear_pre = 1'b1;
        end else begin
          if (tick) begin
            if (secs != 6'd0) begin
              nxt_secs = secs - 6'd1;
            end else if (mins != 4'd0) begin
              nxt_secs = SECS_MAX;
              nxt_mins = mins - 4'd1;
            end
          end
          // Expiry wins over a coincident pause: the round is over either way.
          if (tick && mins == 4'd0 && secs <= 6'd1) begin
            nxt_state = EXPIRED;
            nxt_done  = 1'b1;
          end else if (pause) begin
            nxt_state = PAUSED;
          end
        end
      end
      PAUSED: begin
        if (abort) begin
          nxt_state = IDLE;
          nxt_mins  = INIT_M;
          nxt_secs  = INIT_S;
          clear_pre = 1'b1;
        end else if (pause) begin
          nxt_state = RUNNING;
        end
      end
      EXPIRED: begin
        if (abort) begin
          nxt_state = IDLE;
          nxt_mins  = INIT_M;
          nxt_secs  = INIT_S;
          clear_pre = 1'b1;
        end else if (start) begin
          nxt_state = RUNNING;
          nxt_mins  = INIT_M;
          nxt_secs  = INIT_S;
          clear_pre = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_mins  = INIT_M;
        nxt_secs  = INIT_S;
        clear_pre = 1'b1;
      end
    endcase
  end

  // Register state, time and the status flags so every output changes only on the clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= IDLE;
      mins      <= INIT_M;
      secs      <= INIT_S;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      mins      <= nxt_mins;
      secs      <= nxt_secs;
      running   <= (nxt_state == RUNNING);
      done      <= nxt_done;
    end
  end

`ifdef ROUND_TIMER_WARN_EN
  logic nxt_warn;

  assign nxt_warn = ((nxt_state == RUNNING) || (nxt_state == PAUSED)) &&
                    (nxt_mins == 4'd0) && (nxt_secs != 6'd0) &&
                    (nxt_secs <= 6'(WARN_SECS));

  // Warning follows the next time value so it lines up with the displayed mins/secs.
  always_ff @(posedge clock) begin
    if (reset) begin
      warn <= 1'b0;
    end else begin
      warn <= nxt_warn;
    end
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - directed self-checking bench for round_timer_ctrl at CLK_HZ=4, 1:02 rounds
module tb_round_timer_ctrl;

`ifdef ROUND_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       start;
  logic       pause;
  logic       abort;
  logic [3:0] mins;
  logic [5:0] secs;
  logic [1:0] state;
  logic       running;
  logic       done;
  logic       warn;

  int n_vec;
  int n_miss;

  round_timer_ctrl #(
    .CLK_HZ    (4),
    .INIT_MIN  (1),
    .INIT_SEC  (2),
    .WARN_SECS (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .abort   (abort),
    .mins    (mins),
    .secs    (secs),
    .state   (state),
    .running (running),
    .done    (done),
    .warn    (warn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic s, input logic p, input logic a);
    start = s;
    pause = p;
    abort = a;
    step(1);
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_time(input string tag, input int m, input int s, input int st);
    check({tag, "_mins"}, 32'(mins), 32'(m));
    check({tag, "_secs"}, 32'(secs), 32'(s));
    check({tag, "_state"}, 32'(state), 32'(st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int rem;
    int em;
    int es;
    int est;
    int ndone;
    logic ew;

    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    abort  = 1'b0;
    step(2);
    check_time("rst", 1, 2, 0);
    check("rst_done", 32'(done), 0);
    check("rst_warn", 32'(warn), 0);
    check("rst_running", 32'(running), 0);
    reset = 1'b0;
    step(1);
    check_time("idle", 1, 2, 0);

    // Full round: one-second steps every 4 cycles, done at cycle 248.
    cmd(1'b1, 1'b0, 1'b0);
    check_time("s1_start", 1, 2, 1);
    check("s1_running", 32'(running), 1);
    ndone = 0;
    for (int k = 1; k <= 248; k++) begin
      step(1);
      rem = 62 - (k / 4);
      em  = rem / 60;
      es  = rem % 60;
      est = (k == 248) ? 3 : 1;
      ew  = WARN_ON && (em == 0) && (es >= 1) && (es <= 3) && (est == 1);
      if (done === 1'b1) ndone++;
      check_time("s1_run", em, es, est);
      check("s1_done", 32'(done), (k == 248) ? 32'd1 : 32'd0);
      check("s1_warn", 32'(warn), 32'(ew));
    end
    check("s1_done_pulses", 32'(ndone), 1);
    step(1);
    check("s1_done_after", 32'(done), 0);
    check_time("s1_hold", 0, 0, 3);
    step(5);
    check_time("s1_hold5", 0, 0, 3);
    check("s1_hold_running", 32'(running), 0);

    // Restart after expiry, pause at 0:59 with prescaler frozen at 2.
    cmd(1'b1, 1'b0, 1'b0);
    check_time("s2_restart", 1, 2, 1);
    step(13);
    check_time("s2_059", 0, 59, 1);
    cmd(1'b0, 1'b1, 1'b0);
    check_time("s2_paused", 0, 59, 2);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check_time("s2_frozen", 0, 59, 2);
    end
    cmd(1'b0, 1'b1, 1'b0);
    check_time("s2_resume", 0, 59, 1);
    step(1);
    check_time("s2_resume1", 0, 59, 1);
    step(1);
    check_time("s2_resume2", 0, 58, 1);

    // Abort while paused at 0:30.
    step(112);
    check_time("s3_030", 0, 30, 1);
    cmd(1'b0, 1'b1, 1'b0);
    check_time("s3_paused", 0, 30, 2);
    cmd(1'b0, 1'b0, 1'b1);
    check_time("s3_abort", 1, 2, 0);
    check("s3_abort_done", 32'(done), 0);
    check("s3_abort_running", 32'(running), 0);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (done !== 1'b0) ndone++;
    end
    check("s3_no_done", 32'(ndone), 0);
    check_time("s3_idle", 1, 2, 0);

    // Start+pause from IDLE runs; abort+start while running goes IDLE.
    cmd(1'b1, 1'b1, 1'b0);
    check_time("s4_sp", 1, 2, 1);
    check("s4_sp_running", 32'(running), 1);
    step(4);
    check_time("s4_tick", 1, 1, 1);
    cmd(1'b1, 1'b0, 1'b1);
    check_time("s4_as", 1, 2, 0);
    check("s4_as_running", 32'(running), 0);

    // Warning holds while paused inside the final seconds.
    cmd(1'b1, 1'b0, 1'b0);
    step(239);
    check_time("s5_003", 0, 3, 1);
    check("s5_warn3", 32'(warn), 32'(WARN_ON));
    step(1);
    check_time("s5_002", 0, 2, 1);
    cmd(1'b0, 1'b1, 1'b0);
    check_time("s5_paused", 0, 2, 2);
    check("s5_warn_paused", 32'(warn), 32'(WARN_ON));
    step(10);
    check("s5_warn_paused10", 32'(warn), 32'(WARN_ON));
    cmd(1'b0, 1'b0, 1'b1);
    check_time("s5_abort", 1, 2, 0);
    check("s5_warn_abort", 32'(warn), 0);

    // Reset mid-round at 0:10.
    cmd(1'b1, 1'b0, 1'b0);
    step(208);
    check_time("s6_010", 0, 10, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_time("s6_reset", 1, 2, 0);
    check("s6_done", 32'(done), 0);
    check("s6_warn", 32'(warn), 0);
    check("s6_running", 32'(running), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
